// File: rtl/if_id_inst_buffer_pkg.sv
// Shared definitions for the fetch-to-decode instruction buffer.
// Holds the packet layout (field positions, packed view of the bus) and
// small helpers used by the buffer and by anything that needs to pick
// fields out of a fetched packet.
package if_id_inst_buffer_pkg;

    // Width of one fetched packet on the fetch -> decode bus.
    localparam int unsigned IF_TO_ID_BUS_SIZE = 66;

    // Field positions inside a packet.
    localparam int unsigned IFID_EXCP_EN_BIT  = 65;
    localparam int unsigned IFID_EXCP_NUM_BIT = 64;
    localparam int unsigned IFID_PC_LSB       = 32;
    localparam int unsigned IFID_INST_LSB     = 0;
    localparam int unsigned IFID_WORD_W       = 32;

    // Default queue depth.
    localparam int unsigned IFID_DEFAULT_DEPTH = 4;

    // Packed view of one packet; first member sits at the MSB.
    typedef struct packed {
        logic                   excp_en;
        logic                   excp_num;
        logic [IFID_WORD_W-1:0] pc;
        logic [IFID_WORD_W-1:0] inst;
    } ifid_bus_t;

    // Extract the pc field from a raw packet.
    function automatic logic [IFID_WORD_W-1:0] ifid_pc(
        input logic [IF_TO_ID_BUS_SIZE-1:0] bus
    );
        return bus[IFID_PC_LSB +: IFID_WORD_W];
    endfunction

    // Extract the instruction word from a raw packet.
    function automatic logic [IFID_WORD_W-1:0] ifid_inst(
        input logic [IF_TO_ID_BUS_SIZE-1:0] bus
    );
        return bus[IFID_INST_LSB +: IFID_WORD_W];
    endfunction

endpackage : if_id_inst_buffer_pkg

// File: rtl/if_id_inst_buffer.sv
// Decoupling instruction queue between fetch and decode.
// Accepts fetched packets over a valid/allow_in handshake, holds up to DEPTH
// of them and presents the oldest to decode first-word-fall-through. A kill
// (flush or br_cancel) empties the queue in one cycle and drops the packet
// offered in that cycle. Packet contents, including the exception bits, are
// carried opaquely.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   in_valid     fetch has a packet
//   in_allow_in  buffer can accept a packet this cycle (from registered state)
//   in_bus       fetched packet {excp_en, excp_num, pc, inst}
//   out_valid    head packet valid toward decode (forced low in a kill cycle)
//   out_ready    decode accepts the head packet this cycle
//   out_bus      head packet, all zeros when out_valid is low
//   flush        exception / ertn flush from writeback
//   br_cancel    taken branch resolved in decode
//   count        occupancy
//
// DEPTH must be a power of two in 2..16 so the pointers wrap naturally.
module if_id_inst_buffer
    import if_id_inst_buffer_pkg::*;
#(
    parameter int unsigned BUS_W = IF_TO_ID_BUS_SIZE,
    parameter int unsigned DEPTH = IFID_DEFAULT_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_allow_in,
    input  logic [BUS_W-1:0] in_bus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_bus,
    input  logic             flush,
    input  logic             br_cancel,
    output logic [PTR_W:0]   count
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage and state registers.
    logic [BUS_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic kill;
    logic push;
    logic pop;
    logic not_empty;

    // Handshake and head-of-queue decode.
    // Outputs are qualified with reset so they read as empty during the
    // reset cycle even before the registers have been cleared.
    always_comb begin
        kill        = flush | br_cancel;
        not_empty   = (count_q != '0);
        in_allow_in = reset | (count_q != FULL_CNT);
        out_valid   = not_empty & ~kill & ~reset;
        push        = in_valid & in_allow_in & ~kill & ~reset;
        pop         = out_valid & out_ready;
        out_bus     = out_valid ? mem[rd_ptr_q] : '0;
        count       = reset ? '0 : count_q;
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (kill) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // Simultaneous push and pop leave occupancy unchanged.
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State register; reset wins over push, pop and kill.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet array; contents are not reset, only the write is qualified.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_bus;
        end
    end

    // Occupancy can never exceed the array size.
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_q <= FULL_CNT);

    // Decode never pops an empty queue.
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        pop |-> not_empty);

endmodule : if_id_inst_buffer

// File: tb/tb_if_id_inst_buffer.sv
// Bench for the fetch-to-decode instruction buffer.
// A queue of expected packets mirrors what the buffer should hold; each
// scenario task drives stimulus and compares outputs against it inline.
module tb_if_id_inst_buffer;
    import if_id_inst_buffer_pkg::*;

    localparam int unsigned BUS_W = IF_TO_ID_BUS_SIZE;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_allow_in;
    logic [BUS_W-1:0] in_bus;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] out_bus;
    logic             flush;
    logic             br_cancel;
    logic [PTR_W:0]   count;

    logic [BUS_W-1:0] sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    if_id_inst_buffer #(.BUS_W(BUS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_allow_in(in_allow_in), .in_bus(in_bus),
        .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus),
        .flush(flush), .br_cancel(br_cancel), .count(count)
    );

    always #5 clk = ~clk;

    // Packet with inst and exception bits derived from pc.
    function automatic logic [BUS_W-1:0] mk(input logic [31:0] pc);
        ifid_bus_t b;
        b.excp_en  = pc[2];
        b.excp_num = pc[3];
        b.pc       = pc;
        b.inst     = ~pc ^ 32'h0000_5a5a;
        return b;
    endfunction

    // Advance one clock and update the expected-contents model.
    task automatic tick();
        bit k, v, allow, p, pp;
        k     = flush | br_cancel;
        v     = (sb.size() != 0) && !k;
        allow = (sb.size() != DEPTH);
        p     = in_valid && allow && !k;
        pp    = v && out_ready;
        @(posedge clk);
        #1;
        if (reset || k) begin
            sb.delete();
        end else begin
            if (pp) void'(sb.pop_front());
            if (p)  sb.push_back(in_bus);
        end
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_bus    = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        br_cancel = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || out_bus !== '0 || count !== '0 || in_allow_in !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cycle: got v=%b bus=%h cnt=%0d allow=%b want v=0 bus=0 cnt=0 allow=1",
                     out_valid, out_bus, count, in_allow_in);
        end
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || out_bus !== '0 || count !== '0 || in_allow_in !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: got v=%b bus=%h cnt=%0d allow=%b want v=0 bus=0 cnt=0 allow=1",
                     out_valid, out_bus, count, in_allow_in);
        end
    endtask

    task automatic test_fill_drain();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_bus   = mk(32'h1c00_0000 + 32'(4 * i));
            #1;
            n_assert++;
            if (count !== 3'(i) || in_allow_in !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_count: got cnt=%0d allow=%b want cnt=%0d allow=1", count, in_allow_in, i);
            end
            if (i > 0) begin
                n_assert++;
                if (out_bus[IFID_PC_LSB +: 32] !== 32'h1c00_0000) begin
                    n_fail++;
                    $display("FAIL fill_head: got pc=%h want 1c000000", out_bus[IFID_PC_LSB +: 32]);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_assert++;
        if (count !== 3'd4 || in_allow_in !== 1'b0 || out_valid !== 1'b1
            || out_bus[IFID_PC_LSB +: 32] !== 32'h1c00_0000) begin
            n_fail++;
            $display("FAIL full_state: got cnt=%0d allow=%b v=%b pc=%h want cnt=4 allow=0 v=1 pc=1c000000",
                     count, in_allow_in, out_valid, out_bus[IFID_PC_LSB +: 32]);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_assert++;
            if (out_valid !== 1'b1 || sb.size() == 0 || out_bus !== sb[0]
                || out_bus[IFID_PC_LSB +: 32] !== 32'h1c00_0000 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL drain_order: got v=%b bus=%h want pc=%h", out_valid, out_bus,
                         32'h1c00_0000 + 32'(4 * i));
            end
            tick();
        end
        out_ready = 1'b0;
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || out_bus !== '0 || count !== '0) begin
            n_fail++;
            $display("FAIL drained: got v=%b bus=%h cnt=%0d want v=0 bus=0 cnt=0", out_valid, out_bus, count);
        end
    endtask

    task automatic test_full_push_pop();
        int budget;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_bus   = mk(32'h1c00_0040 + 32'(4 * i));
            tick();
        end
        in_bus    = mk(32'h1c00_0080);
        out_ready = 1'b1;
        #1;
        n_assert++;
        if (in_allow_in !== 1'b0 || out_valid !== 1'b1 || out_bus !== sb[0]) begin
            n_fail++;
            $display("FAIL full_pushpop_cycle: got allow=%b v=%b bus=%h want allow=0 v=1 bus=%h",
                     in_allow_in, out_valid, out_bus, sb[0]);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_assert++;
        if (count !== 3'd3 || in_allow_in !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pushpop_next: got cnt=%0d allow=%b want cnt=3 allow=1", count, in_allow_in);
        end
        budget = 0;
        while (sb.size() != 0 && budget < 8) begin
            #1;
            n_assert++;
            if (out_valid !== 1'b1 || out_bus !== sb[0]) begin
                n_fail++;
                $display("FAIL full_pushpop_drain: got v=%b bus=%h want v=1 bus=%h", out_valid, out_bus, sb[0]);
            end
            tick();
            budget++;
        end
        out_ready = 1'b0;
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL full_pushpop_empty: got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
        end
    endtask

    task automatic test_wrap();
        int tx = 0;
        int rx = 0;
        int cyc = 0;
        idle_inputs();
        while (rx < 10 && cyc < 100) begin
            in_valid  = (tx < 10);
            in_bus    = mk(32'h1c00_0300 + 32'(4 * tx));
            out_ready = cyc[0];
            #1;
            n_assert++;
            if (count !== 3'(sb.size()) || out_valid !== (sb.size() != 0)) begin
                n_fail++;
                $display("FAIL wrap_state: got cnt=%0d v=%b want cnt=%0d", count, out_valid, sb.size());
            end
            if (sb.size() != 0 && out_ready) begin
                n_assert++;
                if (out_bus !== sb[0] || out_bus[IFID_PC_LSB +: 32] !== 32'h1c00_0300 + 32'(4 * rx)) begin
                    n_fail++;
                    $display("FAIL wrap_order: got bus=%h want pc=%h", out_bus, 32'h1c00_0300 + 32'(4 * rx));
                end
                rx++;
            end
            if (in_valid && sb.size() != DEPTH) tx++;
            tick();
            cyc++;
        end
        idle_inputs();
        n_assert++;
        if (rx != 10) begin
            n_fail++;
            $display("FAIL wrap_timeout: got %0d packets want 10", rx);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_bus   = mk(32'h1c00_00c0 + 32'(4 * i));
            tick();
        end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_bus    = mk(32'h1c00_0100);
        out_ready = 1'b1;
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || out_bus !== '0 || count !== 3'd2) begin
            n_fail++;
            $display("FAIL flush_cycle: got v=%b bus=%h cnt=%0d want v=0 bus=0 cnt=2", out_valid, out_bus, count);
        end
        tick();
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_assert++;
            if (out_valid !== 1'b0 || count !== '0 || out_bus !== '0) begin
                n_fail++;
                $display("FAIL flush_after: got v=%b cnt=%0d bus=%h want v=0 cnt=0 bus=0", out_valid, count, out_bus);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_br_cancel_refill();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_bus   = mk(32'h1c00_0180 + 32'(4 * i));
            tick();
        end
        in_valid  = 1'b0;
        br_cancel = 1'b1;
        tick();
        br_cancel = 1'b0;
        #1;
        n_assert++;
        if (count !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_empty: got cnt=%0d v=%b want cnt=0 v=0", count, out_valid);
        end
        in_valid = 1'b1;
        in_bus   = mk(32'h1c00_0200);
        #1;
        n_assert++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_no_bypass: got v=%b want v=0", out_valid);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_assert++;
        if (out_valid !== 1'b1 || out_bus !== sb[0] || out_bus !== mk(32'h1c00_0200)) begin
            n_fail++;
            $display("FAIL cancel_refill: got v=%b bus=%h want v=1 bus=%h", out_valid, out_bus, mk(32'h1c00_0200));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL cancel_stale: got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_bus   = mk(32'h1c00_0280 + 32'(4 * i));
            tick();
        end
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_bus    = mk(32'h1c00_02c0);
        out_ready = 1'b1;
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_cycle: got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
        end
        tick();
        reset = 1'b0;
        idle_inputs();
        #1;
        n_assert++;
        if (count !== '0 || out_valid !== 1'b0 || out_bus !== '0 || in_allow_in !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_after: got cnt=%0d v=%b bus=%h allow=%b want cnt=0 v=0 bus=0 allow=1",
                     count, out_valid, out_bus, in_allow_in);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_wrap();
        test_flush();
        test_br_cancel_refill();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_if_id_inst_buffer
